// File: rtl/vector_mem_responder_if.sv
// Load/store bus between the vector processing unit (master) and its memory responder (slave).
interface vector_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output mem_addr, mem_read, mem_write, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/vector_mem_responder.sv
// Word-array memory responder for the vector unit: single-cycle writes, fixed-latency reads, host preload.
// Optional range checking is enabled by defining VMEM_BOUNDS_CHECK_EN.
module vector_mem_responder #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 2,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_mem_responder_if.slave mem,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  access_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  logic [31:0]           offset;
  logic [29:0]           word;
  logic [AW-1:0]         idx;
  logic                  oor;
  logic                  unused_addr_bits;

  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_p [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_p;

  assign offset = mem.mem_addr - BASE_ADDR;
  assign word   = offset[31:2];
  // Low byte-lane bits are dropped so misaligned addresses round down to their word.
  assign idx    = word[AW-1:0];
  assign unused_addr_bits = ^{offset[1:0], word};

`ifdef VMEM_BOUNDS_CHECK_EN
  logic err_q;

  assign oor = (mem.mem_addr < BASE_ADDR) || (word >= 30'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((mem.mem_read || mem.mem_write) && oor) begin
      err_q <= 1'b1;
    end
  end

  assign access_err = err_q;
`else
  assign oor        = 1'b0;
  assign access_err = 1'b0;
`endif

  // Array: host write is applied after the bus write so it wins on a shared index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (mem.mem_write && !oor) mem_q[idx] <= mem.wr_data;
      if (host_we) mem_q[host_addr] <= host_wdata;
    end
  end

  // Stage 0 samples the pre-write array contents; later stages only move on valid so rd_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int s = 0; s < RD_LATENCY; s++) data_p[s] <= '0;
    end else begin
      vld_p[0] <= mem.mem_read;
      if (mem.mem_read) data_p[0] <= oor ? '0 : mem_q[idx];
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) data_p[s] <= data_p[s-1];
      end
    end
  end

  assign mem.rd_data  = data_p[RD_LATENCY-1];
  assign mem.rd_valid = vld_p[RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (mem.mem_read)          rd_count <= rd_count + 16'd1;
      if (mem.mem_write && !oor) wr_count <= wr_count + 16'd1;
    end
  end

endmodule
